// File: rtl/param_regfile.sv
// Parametrised register file with pipelined reads, atomic increment and sequenced bulk clear.
// Optional even-parity protection per word is enabled by defining PARAM_REGFILE_PARITY_EN.
module param_regfile #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    RD_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  incr_en,
    input  logic                  clr_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  par_inject,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] incr_out,
    output logic                  incr_valid,
    output logic                  clr_done,
    output logic                  rd_par_err,
    output logic [1:0]            fsm_state
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMW   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rmw_addr;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] inc_val;
    logic                  do_clr, do_wr, do_inc, do_rd;
    logic                  rd_err_now;

    logic [DATA_WIDTH-1:0] rd_data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [RD_LATENCY-1:0] rd_err_q;

    // Handshake: a request is taken only on a rising edge where ready=1; requests seen
    // while ready=0 are dropped. rd_valid/incr_valid/clr_done are single-cycle pulses.
    assign do_clr = ready & clr_req;
    assign do_wr  = ready & ~clr_req & write_en;
    assign do_inc = ready & ~clr_req & ~write_en & incr_en;
    assign do_rd  = ready & ~clr_req & ~write_en & ~incr_en & read_en;

    assign inc_val   = mem[rmw_addr] + DATA_WIDTH'(1);
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (do_clr)      next_state = CLEAR;
                else if (do_inc) next_state = RMW;
            end
            RMW:     next_state = IDLE;
            CLEAR:   if (clr_cnt == LAST_ADDR) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b0;
            rmw_addr   <= '0;
            clr_cnt    <= '0;
            incr_out   <= '0;
            incr_valid <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            state      <= next_state;
            ready      <= (next_state == IDLE);
            incr_valid <= (state == RMW);
            clr_done   <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
            if (state == RMW) incr_out <= inc_val;
            if (do_inc) rmw_addr <= addr;
            if (do_clr) clr_cnt <= '0;
            else if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Write, increment and clear never overlap: writes need IDLE, the others own their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else begin
            if (do_wr) mem[addr] <= data_in;
            if (state == RMW) mem[rmw_addr] <= inc_val;
            if (state == CLEAR) mem[clr_cnt] <= RESET_VAL;
        end
    end

`ifdef PARAM_REGFILE_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= ^RESET_VAL;
        end else begin
            if (do_wr) par_mem[addr] <= (^data_in) ^ par_inject;
            if (state == RMW) par_mem[rmw_addr] <= ^inc_val;
            if (state == CLEAR) par_mem[clr_cnt] <= ^RESET_VAL;
        end
    end

    assign rd_err_now = (^mem[addr]) ^ par_mem[addr];
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
    assign rd_err_now        = 1'b0;
`endif

    // Stage 0 samples memory on the accept edge; the last stage drives the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= '0;
            rd_vld_q <= '0;
            rd_err_q <= '0;
        end else begin
            rd_data_q[0] <= mem[addr];
            rd_vld_q[0]  <= do_rd;
            rd_err_q[0]  <= do_rd & rd_err_now;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_data_q[i] <= rd_data_q[i-1];
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_err_q[i]  <= rd_err_q[i-1];
            end
        end
    end

    assign data_out   = rd_data_q[RD_LATENCY-1];
    assign rd_valid   = rd_vld_q[RD_LATENCY-1];
    assign rd_par_err = rd_err_q[RD_LATENCY-1];

endmodule

// File: tb/tb_param_regfile.sv
// Directed testbench for param_regfile (default parameters: 8-bit data, 16 words, read latency 2).
module tb_param_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0, read_en = 1'b0, incr_en = 1'b0, clr_req = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       par_inject = 1'b0;
    logic       ready, rd_valid, incr_valid, clr_done, rd_par_err;
    logic [7:0] data_out, incr_out;
    logic [1:0] fsm_state;

    int checks = 0;
    int failures = 0;
    int wait_cnt;
    logic saw_done;

    param_regfile dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .incr_en(incr_en),
        .clr_req(clr_req), .addr(addr), .data_in(data_in), .par_inject(par_inject),
        .ready(ready), .data_out(data_out), .rd_valid(rd_valid), .incr_out(incr_out),
        .incr_valid(incr_valid), .clr_done(clr_done), .rd_par_err(rd_par_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic inj);
        write_en = 1'b1; addr = a; data_in = d; par_inject = inj;
        tick();
        write_en = 1'b0; par_inject = 1'b0;
    endtask

    // Single read; result is visible two cycles after the accept cycle.
    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp_d,
                            input logic exp_err);
        read_en = 1'b1; addr = a;
        tick();
        read_en = 1'b0;
        chk({tag, "_early"}, 64'(rd_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_data"}, 64'(data_out), 64'(exp_d));
        chk({tag, "_par"}, 64'(rd_par_err), 64'(exp_err));
        tick();
        chk({tag, "_pulse"}, 64'(rd_valid), 64'd0);
    endtask

    // Back-to-back reads of every word; word i must return base + i*step.
    task automatic read_all(input string tag, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] exp_d;
        for (int i = 0; i < 18; i++) begin
            read_en = (i < 16); addr = 4'(i);
            tick();
            read_en = 1'b0;
            if (i >= 1 && i <= 16) begin
                exp_d = base + 8'(i - 1) * step;
                chk($sformatf("%s_valid%0d", tag, i - 1), 64'(rd_valid), 64'd1);
                chk($sformatf("%s_data%0d", tag, i - 1), 64'(data_out), 64'(exp_d));
            end else begin
                chk($sformatf("%s_idle%0d", tag, i), 64'(rd_valid), 64'd0);
            end
        end
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_incr_out", 64'(incr_out), 64'd0);
        chk("rst_incr_valid", 64'(incr_valid), 64'd0);
        chk("rst_clr_done", 64'(clr_done), 64'd0);
        chk("rst_par_err", 64'(rd_par_err), 64'd0);
        tick();
        tick();
        chk("rst_held_ready", 64'(ready), 64'd0);
        rst = 1'b0;
        chk("rel_ready_before_edge", 64'(ready), 64'd0);
        tick();
        chk("rel_ready", 64'(ready), 64'd1);

        // Write then immediate read
        wr(4'd3, 8'hA5, 1'b0);
        rd_check("wr_rd3", 4'd3, 8'hA5, 1'b0);

        // Pipelined reads of addr*3
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 3), 1'b0);
        read_all("seq3", 8'h00, 8'h03);

        // Increment with wrap, and a write dropped while ready=0
        wr(4'd7, 8'hFF, 1'b0);
        incr_en = 1'b1; addr = 4'd7;
        tick();
        incr_en = 1'b0;
        chk("incr_ready_low", 64'(ready), 64'd0);
        chk("incr_state_rmw", 64'(fsm_state), 64'd1);
        write_en = 1'b1; addr = 4'd7; data_in = 8'h55;
        tick();
        write_en = 1'b0;
        chk("incr_ready_back", 64'(ready), 64'd1);
        chk("incr_valid", 64'(incr_valid), 64'd1);
        chk("incr_out_wrap", 64'(incr_out), 64'h00);
        tick();
        chk("incr_valid_pulse", 64'(incr_valid), 64'd0);
        rd_check("incr_rd7", 4'd7, 8'h00, 1'b0);

        // Non-wrapping increment
        wr(4'd5, 8'h41, 1'b0);
        incr_en = 1'b1; addr = 4'd5;
        tick();
        incr_en = 1'b0;
        tick();
        chk("incr5_out", 64'(incr_out), 64'h42);
        tick();
        rd_check("incr_rd5", 4'd5, 8'h42, 1'b0);

        // Priority: write beats incr and read
        write_en = 1'b1; incr_en = 1'b1; read_en = 1'b1; addr = 4'd2; data_in = 8'h11;
        tick();
        write_en = 1'b0; incr_en = 1'b0; read_en = 1'b0;
        chk("prio_ready", 64'(ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("prio_no_incr%0d", i), 64'(incr_valid), 64'd0);
            chk($sformatf("prio_no_rd%0d", i), 64'(rd_valid), 64'd0);
        end
        rd_check("prio_rd2", 4'd2, 8'h11, 1'b0);

        // Full clear
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h80 | 8'(i), 1'b0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_ready_low", 64'(ready), 64'd0);
        wait_cnt = 0;
        while (ready === 1'b0 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
            if (ready === 1'b0) chk("clr_done_early", 64'(clr_done), 64'd0);
        end
        chk("clr_low_cycles", 64'(wait_cnt), 64'd16);
        chk("clr_done", 64'(clr_done), 64'd1);
        tick();
        chk("clr_done_pulse", 64'(clr_done), 64'd0);
        read_all("clr", 8'h00, 8'h00);

        // Reset during clear cycle 5
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h5A, 1'b0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'd0);
        chk("mid_rst_state", 64'(fsm_state), 64'd0);
        tick();
        chk("mid_rst_ready_held", 64'(ready), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done === 1'b1) saw_done = 1'b1;
        end
        chk("mid_rst_no_clr_done", 64'(saw_done), 64'd0);
        chk("mid_rst_ready_back", 64'(ready), 64'd1);
        read_all("mid_rst", 8'h00, 8'h00);

        // Reset with a read in flight drops the pulse
        wr(4'd9, 8'h77, 1'b0);
        read_en = 1'b1; addr = 4'd9;
        tick();
        read_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("inflight_rst_valid", 64'(rd_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("inflight_rst_no_pulse", 64'(rd_valid), 64'd0);
        rd_check("inflight_rst_rd9", 4'd9, 8'h00, 1'b0);

`ifdef PARAM_REGFILE_PARITY_EN
        wr(4'd1, 8'h3C, 1'b1);
        rd_check("par_inject", 4'd1, 8'h3C, 1'b1);
        incr_en = 1'b1; addr = 4'd1;
        tick();
        incr_en = 1'b0;
        tick();
        tick();
        rd_check("par_fixed", 4'd1, 8'h3D, 1'b0);
`else
        wr(4'd1, 8'h3C, 1'b1);
        rd_check("par_ignored", 4'd1, 8'h3C, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
